// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised single-port RAM and its clear sequencer.
package ram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } ram_state_e;

  // Smallest width (at least 1) able to index n distinct words.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks a word counter from 0 to DEPTH-1, restartable, with a done pulse after the last word.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          restart,
  input  logic          start,
  input  logic          step,
  output logic          active,
  output logic          last,
  output logic          done,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // A restart always wins, so no clear write happens on a reset edge.
  always_comb begin
    active = step & ~restart;
    last   = active & (cnt_q == CW'(DEPTH - 1));
    cnt_d  = cnt_q;
    if (restart | start) begin
      cnt_d = '0;
    end else if (active) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
    done_d = last;
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/ram_seq.sv
// Single-port synchronous RAM with req/ack handshake, multi-cycle clear and a debug window on the low words.
// Optional per-word parity with error injection is enabled by defining RAM_PARITY_EN.
module ram_seq
  import ram_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned AW        = 8,
  parameter int unsigned DBG_WORDS = 16
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    clr_req,
  input  logic                    req,
  input  logic                    we,
  input  logic [AW-1:0]           addr,
  input  logic [DW-1:0]           wdata,
  input  logic                    perr_inj,
  output logic                    ready,
  output logic                    ack,
  output logic [DW-1:0]           rdata,
  output logic                    clr_done,
  output logic                    perr,
  output logic [DBG_WORDS*DW-1:0] dbg_bus
);

  localparam int unsigned DEPTH = 2 ** AW;

  ram_state_e state_q, state_d;

  logic          clr_active, clr_last;
  logic [AW-1:0] clr_cnt;
  logic          start_clr, access;

  logic [DW-1:0] mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic          ack_q, ack_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          perr_q, perr_d;

  ram_clr_seq #(
    .DEPTH (DEPTH)
  ) u_clr_seq (
    .clk     (clk),
    .restart (clr),
    .start   (start_clr),
    .step    (state_q == ST_CLEAR),
    .active  (clr_active),
    .last    (clr_last),
    .done    (clr_done),
    .cnt     (clr_cnt)
  );

  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_CLEAR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clr_req)  state_d = ST_CLEAR;
      ST_CLEAR: if (clr_last) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // A clear request in IDLE pre-empts any access offered in the same cycle.
  always_comb begin
    ready     = (state_q == ST_IDLE);
    start_clr = ready & clr_req & ~clr;
    access    = ready & req & ~clr_req & ~clr;
  end

  always_comb begin
    mem_we    = clr_active | (access & we);
    mem_waddr = clr_active ? clr_cnt : addr;
    mem_wdata = clr_active ? '0 : wdata;
    ack_d     = access;
    rdata_d   = rdata_q;
    if (start_clr) begin
      rdata_d = '0;
    end else if (access & ~we) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

`ifdef RAM_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic             mem_wpar;

  always_comb begin
    mem_wpar = clr_active ? 1'b0 : ((^wdata) ^ perr_inj);
    perr_d   = access & ~we & (par_q[addr] != (^mem_q[addr]));
  end

  always_ff @(posedge clk) begin
    if (mem_we) par_q[mem_waddr] <= mem_wpar;
  end
`else
  logic unused_perr_inj;
  assign unused_perr_inj = perr_inj;
  assign perr_d          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign perr  = perr_q;

  for (genvar i = 0; i < DBG_WORDS; i++) begin : g_dbg
    assign dbg_bus[i*DW +: DW] = mem_q[i];
  end

endmodule

// File: tb/tb_ram_seq.sv
// Self-checking bench for ram_seq: directed scenarios followed by randomized traffic against a word-level model.
module tb_ram_seq;

   localparam int DW        = 8;
   localparam int AW        = 8;
   localparam int DBG_WORDS = 16;
   localparam int DEPTH     = 2 ** AW;
   localparam int BW        = DBG_WORDS * DW;

`ifdef RAM_PARITY_EN
   localparam logic PAR_ON = 1'b1;
`else
   localparam logic PAR_ON = 1'b0;
`endif

   logic          clock;
   logic          clr, clrReq, req, we, perrInj;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ready, ack, clrDone, perr;
   logic [DW-1:0] rdata;
   logic [BW-1:0] dbgBus;

   // Word-level model: memory image, injected-parity flags, last read value and words still to clear.
   logic [DW-1:0] refMem [DEPTH];
   bit            refBad [DEPTH];
   logic [DW-1:0] refRdata;
   int            clearLeft;
   bit            initDone;

   int assertCount;
   int failCount;

   ram_seq #(
      .DW        (DW),
      .AW        (AW),
      .DBG_WORDS (DBG_WORDS)
   ) dut (
      .clk      (clock),
      .clr      (clr),
      .clr_req  (clrReq),
      .req      (req),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .perr_inj (perrInj),
      .ready    (ready),
      .ack      (ack),
      .rdata    (rdata),
      .clr_done (clrDone),
      .perr     (perr),
      .dbg_bus  (dbgBus)
   );

   // Free-running 10 ns clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [BW-1:0] observed, input logic [BW-1:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, advances the model across the edge, then compares all outputs.
   task automatic applyStimulus(input logic c, input logic cr, input logic rq, input logic w,
                                input logic [AW-1:0] a, input logic [DW-1:0] d, input logic inj);
      logic          expAck, expDone, expPerr;
      logic [BW-1:0] expDbg;
      clr = c; clrReq = cr; req = rq; we = w; addr = a; wdata = d; perrInj = inj;
      expAck = 1'b0; expDone = 1'b0; expPerr = 1'b0;
      if (c) begin
         clearLeft = DEPTH;
         refRdata  = '0;
      end else if (clearLeft > 0) begin
         refMem[DEPTH - clearLeft] = '0;
         refBad[DEPTH - clearLeft] = 1'b0;
         clearLeft--;
         if (clearLeft == 0) begin
            expDone  = 1'b1;
            initDone = 1'b1;
         end
      end else if (cr) begin
         clearLeft = DEPTH;
         refRdata  = '0;
      end else if (rq) begin
         expAck = 1'b1;
         if (w) begin
            refMem[a] = d;
            refBad[a] = inj;
         end else begin
            refRdata = refMem[a];
            expPerr  = PAR_ON & refBad[a];
         end
      end
      @(posedge clock);
      #1;
      checkOutput("ready", ready, clearLeft == 0);
      checkOutput("ack", ack, expAck);
      checkOutput("clrDone", clrDone, expDone);
      checkOutput("rdata", rdata, refRdata);
      checkOutput("perr", perr, expPerr);
      if (initDone) begin
         for (int i = 0; i < DBG_WORDS; i++) expDbg[i*DW +: DW] = refMem[i];
         checkOutput("dbgBus", dbgBus, expDbg);
      end
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   // Hard stop in case the design wedges the simulation.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: directed scenarios, then randomized traffic, then the summary.
   initial begin
      int n;
      int lowCycles;
      logic c, cr, rq, w, inj;
      logic [AW-1:0] a;
      logic [DW-1:0] d;

      assertCount = 0;
      failCount   = 0;
      clearLeft   = 0;
      initDone    = 1'b0;
      clr = 1'b0; clrReq = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; perrInj = 1'b0;

      $display("[TB] reset and full clear");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      lowCycles = (ready == 1'b0) ? 1 : 0;
      n = 0;
      while (!clrDone && n < 400) begin
         idleCycle();
         if (!ready) lowCycles++;
         n++;
      end
      checkOutput("clrDoneAt", n, 256);
      checkOutput("clrLow", lowCycles, 256);
      checkOutput("dbgZero", dbgBus, '0);
      idleCycle();

      $display("[TB] write then read 0x03");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 8'hA5, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 8'h00, 1'b0);
      checkOutput("read03", rdata, 8'hA5);
      checkOutput("dbgWord3", dbgBus[31:24], 8'hA5);
      idleCycle();

      $display("[TB] top address");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h7F, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
      checkOutput("readFF", rdata, 8'h7F);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      checkOutput("read00", rdata, 8'h00);

      $display("[TB] clear request with a held read");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h11, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 8'h22, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h80, 8'h00, 1'b0);
      lowCycles = (ready == 1'b0) ? 1 : 0;
      n = 0;
      while (!ready && n < 400) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 8'h00, 1'b0);
         if (!ready) lowCycles++;
         n++;
      end
      checkOutput("clrReqLow", lowCycles, 256);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 8'h00, 1'b0);
      checkOutput("heldAck", ack, 1'b1);
      checkOutput("heldRead", rdata, 8'h00);
      idleCycle();

      $display("[TB] reset in the middle of a clear");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      repeat (100) idleCycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      n = 0;
      while (!clrDone && n < 400) begin
         idleCycle();
         n++;
      end
      checkOutput("restartDone", n, 256);
      idleCycle();

      $display("[TB] parity injection");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 8'h3C, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0);
      checkOutput("injAck", ack, 1'b1);
      checkOutput("injPerr", perr, PAR_ON);
      checkOutput("injRdata", rdata, 8'h3C);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h06, 8'h3C, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h06, 8'h00, 1'b0);
      checkOutput("cleanPerr", perr, 1'b0);
      idleCycle();

      $display("[TB] randomized traffic");
      for (int i = 0; i < 800; i++) begin
         n   = int'($urandom_range(0, 199));
         c   = (n == 0);
         cr  = (n >= 1 && n <= 2);
         rq  = ($urandom_range(0, 3) != 0);
         w   = $urandom_range(0, 1) == 1;
         a   = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, DEPTH - 1));
         d   = DW'($urandom);
         inj = ($urandom_range(0, 3) == 0);
         applyStimulus(c, cr, rq, w, a, d, inj);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
